// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : match_ctrl
//  Purpose  : Round and match controller placed after the collision stage.
//             Counts per-round points on eaten rising edges, latches the
//             round outcome, holds it for HOLD_TICKS game ticks and
//             accumulates round wins until one player takes the match.
//  Ports    : clk, rst (async, active-low)
//             start        - start round / new match (pulse)
//             tick         - game step pulse
//             eaten1/2     - snake head on POINT (level)
//             won/lost/draw- round outcome flags (level)
//             in_game      - high while playing
//             spawn_req    - one-cycle request for a new POINT
//             score1/2     - per-round points (saturating)
//             wins1/2      - round wins this match (saturating)
//             result       - 00 none, 01 P1 won, 10 P1 lost, 11 draw
//             match_over   - high once a player has won the match
//  Revision : 1.0 - initial release
// ============================================================================
module match_ctrl #(
  parameter int SCORE_W       = 8,
  parameter int WINS_W        = 3,
  parameter int WINS_TO_MATCH = 3,
  parameter int HOLD_TICKS    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic               eaten1,
  input  logic               eaten2,
  input  logic               won,
  input  logic               lost,
  input  logic               draw,
  output logic               in_game,
  output logic               spawn_req,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [WINS_W-1:0]  wins1,
  output logic [WINS_W-1:0]  wins2,
  output logic [1:0]         result,
  output logic               match_over
);

  localparam int                 HOLD_W      = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [WINS_W-1:0]  WINS_TARGET = WINS_W'(WINS_TO_MATCH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_RESULT    = 2'd2,
    ST_MATCH_END = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_prev1, r_prev2;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic [SCORE_W-1:0]  r_score1, r_score2, w_score1_nxt, w_score2_nxt;
  logic [WINS_W-1:0]   r_wins1, r_wins2, w_wins1_nxt, w_wins2_nxt;
  logic [1:0]          r_result, w_result_nxt;
  logic                r_spawn, w_spawn_nxt;
  logic                r_in_game, r_match_over;
  logic                w_edge1, w_edge2;

  assign w_edge1 = eaten1 & ~r_prev1;
  assign w_edge2 = eaten2 & ~r_prev2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_prev1      <= 1'b0;
      r_prev2      <= 1'b0;
      r_hold       <= '0;
      r_score1     <= '0;
      r_score2     <= '0;
      r_wins1      <= '0;
      r_wins2      <= '0;
      r_result     <= 2'b00;
      r_spawn      <= 1'b0;
      r_in_game    <= 1'b0;
      r_match_over <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // History samples every cycle so a level already high on PLAY entry
      // is not mistaken for a fresh edge.
      r_prev1      <= eaten1;
      r_prev2      <= eaten2;
      r_hold       <= w_hold_nxt;
      r_score1     <= w_score1_nxt;
      r_score2     <= w_score2_nxt;
      r_wins1      <= w_wins1_nxt;
      r_wins2      <= w_wins2_nxt;
      r_result     <= w_result_nxt;
      r_spawn      <= w_spawn_nxt;
      r_in_game    <= (w_state_nxt == ST_PLAY);
      r_match_over <= (w_state_nxt == ST_MATCH_END);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_score1_nxt = r_score1;
    w_score2_nxt = r_score2;
    w_wins1_nxt  = r_wins1;
    w_wins2_nxt  = r_wins2;
    w_result_nxt = r_result;
    w_spawn_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_PLAY;
          w_score1_nxt = '0;
          w_score2_nxt = '0;
          w_result_nxt = 2'b00;
          w_spawn_nxt  = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_edge1 && (r_score1 != '1)) w_score1_nxt = r_score1 + SCORE_W'(1);
        if (w_edge2 && (r_score2 != '1)) w_score2_nxt = r_score2 + SCORE_W'(1);
        w_spawn_nxt = w_edge1 | w_edge2;
        if (draw || won || lost) begin
          w_state_nxt = ST_RESULT;
          w_hold_nxt  = '0;
          if (draw) begin
            w_result_nxt = 2'b11;
          end else if (won) begin
            w_result_nxt = 2'b01;
            if (r_wins1 != '1) w_wins1_nxt = r_wins1 + WINS_W'(1);
          end else begin
            w_result_nxt = 2'b10;
            if (r_wins2 != '1) w_wins2_nxt = r_wins2 + WINS_W'(1);
          end
        end
      end
      ST_RESULT: begin
        if (tick) begin
          if (r_hold == HOLD_LAST) begin
            if ((r_wins1 >= WINS_TARGET) || (r_wins2 >= WINS_TARGET))
              w_state_nxt = ST_MATCH_END;
            else
              w_state_nxt = ST_IDLE;
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
      end
      ST_MATCH_END: begin
        if (start) begin
          w_state_nxt  = ST_PLAY;
          w_wins1_nxt  = '0;
          w_wins2_nxt  = '0;
          w_score1_nxt = '0;
          w_score2_nxt = '0;
          w_result_nxt = 2'b00;
          w_spawn_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign in_game    = r_in_game;
  assign spawn_req  = r_spawn;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign wins1      = r_wins1;
  assign wins2      = r_wins2;
  assign result     = r_result;
  assign match_over = r_match_over;

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_ctrl
//  Purpose  : Directed self-checking bench for match_ctrl. A default instance
//             (SCORE_W=8) and a narrow instance (SCORE_W=2) share stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_match_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, tick = 1'b0, eaten1 = 1'b0, eaten2 = 1'b0;
  logic won = 1'b0, lost = 1'b0, draw = 1'b0;

  logic       in_game, spawn_req, match_over;
  logic [7:0] score1, score2;
  logic [2:0] wins1, wins2;
  logic [1:0] result;

  logic       s_in_game, s_spawn_req, s_match_over;
  logic [1:0] s_score1, s_score2;
  logic [2:0] s_wins1, s_wins2;
  logic [1:0] s_result;

  always #5 clk = ~clk;

  match_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick),
    .eaten1(eaten1), .eaten2(eaten2), .won(won), .lost(lost), .draw(draw),
    .in_game(in_game), .spawn_req(spawn_req), .score1(score1), .score2(score2),
    .wins1(wins1), .wins2(wins2), .result(result), .match_over(match_over)
  );

  match_ctrl #(.SCORE_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .tick(tick),
    .eaten1(eaten1), .eaten2(eaten2), .won(won), .lost(lost), .draw(draw),
    .in_game(s_in_game), .spawn_req(s_spawn_req), .score1(s_score1), .score2(s_score2),
    .wins1(s_wins1), .wins2(s_wins2), .result(s_result), .match_over(s_match_over)
  );

  typedef struct packed {
    logic       in_game;
    logic       spawn;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [2:0] w1;
    logic [2:0] w2;
    logic [1:0] res;
    logic       mo;
  } out_t;

  out_t  m;
  out_t  expq[$];
  string tagq[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic out_t obs_now();
    return {in_game, spawn_req, score1, score2, wins1, wins2, result, match_over};
  endfunction

  task automatic push(input string tag);
    expq.push_back(m);
    tagq.push_back(tag);
  endtask

  task automatic compare_head();
    out_t  e;
    out_t  o;
    string t;
    e = expq.pop_front();
    t = tagq.pop_front();
    o = obs_now();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask

  task automatic step(input string tag);
    push(tag);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic check_small(input string tag, input logic [1:0] exp_s2);
    vectors++;
    assert (s_score2 === exp_s2) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, s_score2, exp_s2);
    end
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step(tag);
    end
    tick = 1'b0;
  endtask

  task automatic new_round(input string tag);
    start = 1'b1;
    m.in_game = 1'b1; m.spawn = 1'b1; m.s1 = '0; m.s2 = '0; m.res = 2'b00;
    step(tag);
    start = 1'b0;
    m.spawn = 1'b0;
  endtask

  initial begin
    m = '0;
    repeat (2) @(posedge clk);
    #1;
    push("reset_state");
    compare_head();
    rst = 1'b1;
    step("no_spawn_on_release");

    // Round 1: start, point edges
    new_round("start_play");
    step("spawn_one_cycle");

    eaten1 = 1'b1; m.s1 = 8'd1; m.spawn = 1'b1;
    step("e1_rise");
    m.spawn = 1'b0;
    repeat (4) step("e1_held");
    eaten1 = 1'b0;
    step("e1_low");
    eaten1 = 1'b1; m.s1 = 8'd2; m.spawn = 1'b1;
    step("e1_rise2");
    eaten1 = 1'b0; m.spawn = 1'b0;
    step("e1_fall");

    eaten1 = 1'b1; eaten2 = 1'b1; m.s1 = 8'd3; m.s2 = 8'd1; m.spawn = 1'b1;
    step("both_rise_one_spawn");
    eaten1 = 1'b0; eaten2 = 1'b0; m.spawn = 1'b0;
    step("both_fall");

    // draw beats won; eaten edge still counted; entry tick not counted
    won = 1'b1; draw = 1'b1; eaten2 = 1'b1; tick = 1'b1;
    m.in_game = 1'b0; m.res = 2'b11; m.s2 = 8'd2; m.spawn = 1'b1;
    step("draw_priority");
    won = 1'b0; draw = 1'b0; eaten2 = 1'b0; tick = 1'b0; m.spawn = 1'b0;
    ticks(15, "hold_draw");
    start = 1'b1;
    step("start_ignored_in_result");
    start = 1'b0;
    ticks(1, "hold_16th");
    new_round("start_after_16th_tick");

    // Round 2: lost
    lost = 1'b1; m.in_game = 1'b0; m.res = 2'b10; m.w2 = 3'd1;
    step("lost_round");
    lost = 1'b0;
    ticks(16, "hold_lost");
    new_round("start_r3");

    // Round 3: won and lost together -> won
    won = 1'b1; lost = 1'b1; m.in_game = 1'b0; m.res = 2'b01; m.w1 = 3'd1;
    step("won_over_lost");
    won = 1'b0; lost = 1'b0;
    ticks(16, "hold_r3");
    new_round("start_r4");

    won = 1'b1; m.in_game = 1'b0; m.res = 2'b01; m.w1 = 3'd2;
    step("won_r4");
    won = 1'b0;
    ticks(16, "hold_r4");
    new_round("start_r5");

    won = 1'b1; m.in_game = 1'b0; m.res = 2'b01; m.w1 = 3'd3;
    step("won_r5");
    won = 1'b0;
    ticks(15, "hold_r5");
    tick = 1'b1; m.mo = 1'b1;
    step("match_end");
    tick = 1'b0;
    step("match_end_hold");

    start = 1'b1;
    m.in_game = 1'b1; m.spawn = 1'b1; m.s1 = '0; m.s2 = '0; m.res = 2'b00;
    m.w1 = '0; m.w2 = '0; m.mo = 1'b0;
    step("new_match");
    start = 1'b0; m.spawn = 1'b0;

    // Saturation on the narrow instance; start in PLAY ignored
    for (int k = 1; k <= 5; k++) begin
      eaten2 = 1'b1;
      if (k == 3) start = 1'b1;
      m.s2 = 8'(k); m.spawn = 1'b1;
      step("e2_edge");
      check_small("small_score2_sat", (k > 3) ? 2'd3 : 2'(k));
      eaten2 = 1'b0; start = 1'b0; m.spawn = 1'b0;
      step("e2_fall");
    end

    for (int k = 1; k <= 4; k++) begin
      eaten1 = 1'b1; m.s1 = 8'(k); m.spawn = 1'b1;
      step("e1_to_four");
      eaten1 = 1'b0; m.spawn = 1'b0;
      step("e1_to_four_fall");
    end

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b0;
    #1;
    m = '0;
    push("async_reset");
    compare_head();
    check_small("small_async_reset", 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("no_spawn_after_release");
    step("idle_after_release");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
